// File: rtl/rand_delay_timer.sv
// Reaction-time trial timer: waits a randomized delay after start, raises go,
// then measures the cycles until hit. It reports false starts and saturation timeouts.
module rand_delay_timer #(
  parameter int MIN_CYCLES = 1000,
  parameter int MASK_BITS  = 20,
  parameter int RT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [23:0]     randnum,
  input  logic            hit,
  output logic            busy,
  output logic            go,
  output logic            result_valid,
  output logic [RT_W-1:0] result,
  output logic            false_start,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GO    = 2'd2
  } state_t;

  localparam logic [RT_W-1:0] RT_MAX = '1;

  state_t            state, state_n;
  logic [24:0]       delay_cnt, delay_n;
  logic [RT_W-1:0]   rt, rt_n;
  logic              busy_n, go_n, result_valid_n;
  logic [RT_W-1:0]   result_n;
  logic              false_start_n, timeout_n;
  logic [24:0]       delay_load;
  logic              unused_randnum;

  // 25-bit sum so that MIN_CYCLES plus a full 24-bit mask can never wrap
  assign delay_load = 25'(MIN_CYCLES) +
                      {{(25 - MASK_BITS){1'b0}}, randnum[MASK_BITS-1:0]};
  assign unused_randnum = ^randnum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      delay_cnt    <= '0;
      rt           <= '0;
      busy         <= 1'b0;
      go           <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      delay_cnt    <= delay_n;
      rt           <= rt_n;
      busy         <= busy_n;
      go           <= go_n;
      result_valid <= result_valid_n;
      result       <= result_n;
      false_start  <= false_start_n;
      timeout      <= timeout_n;
    end
  end

  always_comb begin
    state_n        = state;
    delay_n        = delay_cnt;
    rt_n           = rt;
    result_valid_n = 1'b0;
    result_n       = result;
    false_start_n  = false_start;
    timeout_n      = timeout;

    case (state)
      IDLE: begin
        if (start) begin
          delay_n = delay_load;
          state_n = ARMED;
        end
      end
      ARMED: begin
        // A hit while armed wins over the final countdown edge
        if (hit) begin
          state_n        = IDLE;
          delay_n        = '0;
          result_valid_n = 1'b1;
          result_n       = '0;
          false_start_n  = 1'b1;
          timeout_n      = 1'b0;
        end else if (delay_cnt == 25'd1) begin
          state_n = GO;
          delay_n = '0;
          rt_n    = '0;
        end else begin
          delay_n = delay_cnt - 25'd1;
        end
      end
      GO: begin
        if (hit) begin
          state_n        = IDLE;
          result_valid_n = 1'b1;
          result_n       = rt;
          false_start_n  = 1'b0;
          timeout_n      = 1'b0;
        end else if (rt == RT_MAX) begin
          state_n        = IDLE;
          result_valid_n = 1'b1;
          result_n       = RT_MAX;
          false_start_n  = 1'b0;
          timeout_n      = 1'b1;
        end else begin
          rt_n = rt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    go_n   = (state_n == GO);
  end

endmodule

// File: tb/tb_rand_delay_timer.sv
// Randomized self-checking bench for rand_delay_timer.
// Each trial's outcome is predicted from the delay and the first hit edge.
module tb_rand_delay_timer;

  localparam int MIN_CYCLES = 4;
  localparam int MASK_BITS  = 4;
  localparam int RT_W       = 4;
  localparam int RT_MAX     = (2 ** RT_W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [23:0]     randnum;
  logic            hit;
  logic            busy;
  logic            go;
  logic            result_valid;
  logic [RT_W-1:0] result;
  logic            false_start;
  logic            timeout;

  int checks = 0;
  int passes = 0;
  int exp_result = 0;
  bit exp_fs = 1'b0;
  bit exp_to = 1'b0;

  rand_delay_timer #(
    .MIN_CYCLES(MIN_CYCLES),
    .MASK_BITS (MASK_BITS),
    .RT_W      (RT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .randnum     (randnum),
    .hit         (hit),
    .busy        (busy),
    .go          (go),
    .result_valid(result_valid),
    .result      (result),
    .false_start (false_start),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    else
      passes++;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_go"}, 32'(go), 32'd0);
    checkOutput({tag, "_rv"}, 32'(result_valid), 32'd0);
    checkOutput({tag, "_result"}, 32'(result), 32'd0);
    checkOutput({tag, "_fs"}, 32'(false_start), 32'd0);
    checkOutput({tag, "_to"}, 32'(timeout), 32'd0);
  endtask

  // Trial outcome from first hit edge k (edges counted after the accept edge):
  // k <= D is a false start, otherwise the player waited k-D-1 GO edges,
  // and if no hit arrives by edge D+16 the counter saturates.
  function automatic void predict(input int d, input int hit_edge, output int end_edge,
                                  output int res, output bit fs, output bit to);
    if (hit_edge <= d) begin
      end_edge = hit_edge; res = 0; fs = 1'b1; to = 1'b0;
    end else if (hit_edge <= d + RT_MAX + 1) begin
      end_edge = hit_edge; res = hit_edge - d - 1; fs = 1'b0; to = 1'b0;
    end else begin
      end_edge = d + RT_MAX + 1; res = RT_MAX; fs = 1'b0; to = 1'b1;
    end
  endfunction

  // Run one trial from IDLE; reset_after > 0 asserts reset after that edge.
  task automatic applyStimulus(input logic [23:0] rn, input int hit_edge,
                               input bit hit_at_start, input int reset_after);
    int d, end_edge, res;
    bit fs, to;
    d = MIN_CYCLES + int'(rn % (2 ** MASK_BITS));
    predict(d, hit_edge, end_edge, res, fs, to);

    start = 1'b1; randnum = rn; hit = hit_at_start;
    @(posedge clk); @(negedge clk);
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_go", 32'(go), 32'd0);
    checkOutput("accept_rv", 32'(result_valid), 32'd0);

    for (int j = 1; j <= end_edge + 1; j++) begin
      if (j > end_edge) begin
        start = 1'b0;
        hit   = 1'($urandom_range(0, 1));
      end else begin
        start = (j == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        hit   = (j >= hit_edge);
      end
      randnum = 24'($urandom);
      @(posedge clk); @(negedge clk);
      if (j == end_edge) begin
        exp_result = res; exp_fs = fs; exp_to = to;
      end
      checkOutput($sformatf("go_e%0d", j), 32'(go), 32'(j >= d && j < end_edge));
      checkOutput($sformatf("busy_e%0d", j), 32'(busy), 32'(j < end_edge));
      checkOutput($sformatf("rv_e%0d", j), 32'(result_valid), 32'(j == end_edge));
      checkOutput($sformatf("result_e%0d", j), 32'(result), 32'(exp_result));
      checkOutput($sformatf("fs_e%0d", j), 32'(false_start), 32'(exp_fs));
      checkOutput($sformatf("to_e%0d", j), 32'(timeout), 32'(exp_to));
      if (j == reset_after && j < end_edge) begin
        reset = 1'b1;
        #1;
        exp_result = 0; exp_fs = 1'b0; exp_to = 1'b0;
        checkAllZero("midreset");
        @(posedge clk); @(negedge clk);
        checkAllZero("inreset");
        reset = 1'b0; start = 1'b0; hit = 1'b0;
        return;
      end
    end
    start = 1'b0; hit = 1'b0;
  endtask

  initial begin
    logic [23:0] rn;
    int d, he, ra;
    reset = 1'b0; start = 1'b0; hit = 1'b0; randnum = '0;
    #1 reset = 1'b1;
    #1 checkAllZero("por");
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checkAllZero("post_reset");

    // hit in IDLE without start must not do anything
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1; randnum = 24'($urandom);
      @(posedge clk); @(negedge clk);
      checkOutput("idle_hit_busy", 32'(busy), 32'd0);
      checkOutput("idle_hit_rv", 32'(result_valid), 32'd0);
    end
    hit = 1'b0;

    $display("[TB] directed trials");
    applyStimulus(24'h00000F, 23, 1'b0, 0);
    applyStimulus(24'hABCDE2, 2, 1'b0, 0);
    applyStimulus(24'h000000, 1000, 1'b0, 0);
    applyStimulus(24'h000005, 1000, 1'b0, 2);
    applyStimulus(24'h000005, 12, 1'b1, 0);
    applyStimulus(24'h000003, 1000, 1'b0, 10);
    applyStimulus(24'hFFFFF0, 5, 1'b0, 0);
    applyStimulus(24'h000002, 7, 1'b0, 0);

    $display("[TB] random trials");
    for (int t = 0; t < 25; t++) begin
      rn = 24'($urandom);
      d  = MIN_CYCLES + int'(rn % (2 ** MASK_BITS));
      he = $urandom_range(1, d + RT_MAX + 3);
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(1, d + 4) : 0;
      applyStimulus(rn, he, 1'($urandom_range(0, 1)), ra);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rand_delay_timer.md
RAND_DELAY_TIMER -- requirements
Module: rand_delay_timer

Interface
REQ-001 SHALL have parameter MIN_CYCLES, default 1000, the minimum armed delay in clock cycles (legal range 1 to 2^24-1).
REQ-002 SHALL have parameter MASK_BITS, default 20, the number of low randnum bits added to the delay (legal range 1 to 24).
REQ-003 SHALL have parameter RT_W, default 16, the width of the reaction counter and result.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-006 start  input  1  request a new trial; sampled only in IDLE.
REQ-007 randnum  input  24  random value from the upstream LFSR; sampled on the start-accept edge.
REQ-008 hit  input  1  player response level, already synchronized and debounced upstream.
REQ-009 busy  output  1  high in ARMED or GO.
REQ-010 go  output  1  stimulus indicator; high only in GO.
REQ-011 result_valid  output  1  one-cycle pulse when a trial ends.
REQ-012 result  output  RT_W  reaction cycles; held until the next result_valid.
REQ-013 false_start  output  1  trial ended by hit during ARMED; held with result.
REQ-014 timeout  output  1  trial ended by reaction counter saturation; held with result.

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, GO; all outputs registered.
REQ-016 IDLE + start=1 at an edge: SHALL load delay D = MIN_CYCLES + randnum[MASK_BITS-1:0], computed in 25 bits with no truncation, then enter ARMED.
REQ-017 ARMED: SHALL decrement the delay counter each edge; at the edge where counter==1 and hit=0, SHALL enter GO, so go rises exactly D edges after the start-accept edge.
REQ-018 ARMED + hit=1 at any edge: SHALL return to IDLE, pulse result_valid, set result=0, false_start=1, timeout=0; go never asserts.
REQ-019 GO entry: SHALL clear the reaction counter rt to 0.
REQ-020 GO + hit=1 at an edge: SHALL set result=rt, false_start=0, timeout=0, pulse result_valid, return to IDLE (hit on first GO edge gives result 0).
REQ-021 GO + hit=0 + rt<2^RT_W-1: SHALL increment rt.
REQ-022 GO + hit=0 + rt==2^RT_W-1: SHALL set result all ones, timeout=1, false_start=0, pulse result_valid, return to IDLE.
REQ-023 start SHALL be ignored in ARMED and GO; randnum SHALL be ignored except on the start-accept edge.
REQ-024 hit SHALL be ignored in IDLE; start=1 and hit=1 together in IDLE SHALL start a trial.
REQ-025 result_valid SHALL be high for exactly one cycle per trial, in the cycle after the ending edge, coincident with busy=0.
REQ-026 result, false_start and timeout SHALL update only with result_valid and hold otherwise.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, busy=0, go=0, result_valid=0, result=0, false_start=0, timeout=0, and clear delay and reaction counters, including mid-ARMED or mid-GO.
REQ-028 After reset deasserts, the first start SHALL be accepted on the next edge with start=1.

Verification (bench parameters MIN_CYCLES=4, MASK_BITS=4, RT_W=4)
REQ-029 Assert reset -> all outputs 0 asynchronously, before any clock edge.
REQ-030 start pulse with randnum=24'h00000F (D=19), hit rising 3 edges after go -> go high 19 edges after accept, result=3, result_valid one cycle, false_start=0, timeout=0.
REQ-031 start with randnum=24'hABCDE2 (D=6), hit at armed edge 2 -> go never high, result=0, false_start=1, result_valid one cycle.
REQ-032 start with randnum=0 (D=4), hit held low -> go high 16 cycles, result=4'hF, timeout=1, busy falls with result_valid.
REQ-033 start again during ARMED, then reset at armed edge 3 -> second start ignored, reset gives go=0 and busy=0 with no result_valid; next start is accepted normally.
REQ-034 start=1 and hit=1 on the same IDLE edge, then hit=0 -> trial starts, no false start, go rises after D edges.
